// File: rtl/adder_pkg.sv
// Shared token type and parameter helpers for the pipelined adder.
// The token carries its operands, partial result and carry from stage to stage.
package adder_pkg;

  localparam int unsigned C_MAX_DATA_W = 64;

  // One in-flight operation. Stage k consumes slice k of a/b and fills slice k of sum.
  typedef struct packed {
    logic                    valid;
    logic                    mode;   // 1 = subtract (b slices inverted, carry-in 1)
    logic                    carry;
    logic [C_MAX_DATA_W-1:0] sum;
    logic [C_MAX_DATA_W-1:0] a;
    logic [C_MAX_DATA_W-1:0] b;
  } stage_tok_t;

  function automatic int unsigned slice_width(input int unsigned data_w,
                                              input int unsigned stages);
    return (stages == 0) ? 0 : data_w / stages;
  endfunction

  function automatic bit cfg_ok(input int unsigned data_w, input int unsigned stages);
    if (stages == 0) return 1'b0;
    return (data_w >= 2) && (data_w <= C_MAX_DATA_W) && (stages <= data_w) &&
           ((data_w % stages) == 0);
  endfunction

endpackage

// File: rtl/adder_stage.sv
// One carry-chain slice of the pipelined adder: adds slice g_idx of the token
// and registers the whole token together with its carry-out and valid bit.
module adder_stage
  import adder_pkg::*;
#(
  parameter int unsigned g_w   = 4,
  parameter int unsigned g_idx = 0
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  stage_tok_t i_tok,
  output logic       o_ready,
  input  logic       i_ready,
  output stage_tok_t o_tok
);

  localparam int unsigned C_LO = g_idx * g_w;

  stage_tok_t       r_tok;
  stage_tok_t       w_next;
  logic [g_w-1:0]   w_b_slice;
  logic [g_w:0]     w_slice_sum;

  // The stage can take a new token when it is empty or its token is leaving.
  assign o_ready = !r_tok.valid || i_ready;
  assign o_tok   = r_tok;

  always_comb begin
    w_b_slice   = i_tok.b[C_LO +: g_w] ^ {g_w{i_tok.mode}};
    w_slice_sum = {1'b0, i_tok.a[C_LO +: g_w]} + {1'b0, w_b_slice} +
                  {{g_w{1'b0}}, i_tok.carry};
    w_next                  = i_tok;
    w_next.sum[C_LO +: g_w] = w_slice_sum[g_w-1:0];
    w_next.carry            = w_slice_sum[g_w];
  end

  // Data registers only load with a real token so a bubble never disturbs o_C.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tok <= '0;
    end else if (o_ready) begin
      if (i_tok.valid) begin
        r_tok <= w_next;
      end else begin
        r_tok.valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pipe_adder.sv
// Pipelined unsigned adder split into g_stages carry-chain slices with a
// valid/ready handshake on both sides. Define ADDER_SUB_EN to add i_sub (A-B mode).
//
// Handshake: a transfer happens on a clock edge where valid && ready are both
// high; o_valid/o_C stay stable while stalled, and o_ready may depend on i_ready
// combinationally through the stage chain.
module pipe_adder
  import adder_pkg::*;
#(
  parameter int unsigned g_data_width = 8,
  parameter int unsigned g_stages     = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [g_data_width-1:0] i_A,
  input  logic [g_data_width-1:0] i_B,
`ifdef ADDER_SUB_EN
  input  logic                    i_sub,
`endif
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [g_data_width:0]   o_C
);

  localparam int unsigned C_W = slice_width(g_data_width, g_stages);

  if (!cfg_ok(g_data_width, g_stages)) begin : g_cfg_err
    $error("pipe_adder: g_data_width must be >=2, <=64 and a multiple of g_stages");
  end

  logic       w_mode;
  stage_tok_t w_tok_in;
  stage_tok_t w_tok_last;
  logic       w_unused_tok;

`ifdef ADDER_SUB_EN
  assign w_mode = i_sub;
`else
  assign w_mode = 1'b0;
`endif

  // Subtraction is A + ~B + 1: the mode bit doubles as the stage-0 carry-in.
  always_comb begin
    w_tok_in                       = '0;
    w_tok_in.valid                 = i_valid;
    w_tok_in.mode                  = w_mode;
    w_tok_in.carry                 = w_mode;
    w_tok_in.a[g_data_width-1:0]   = i_A;
    w_tok_in.b[g_data_width-1:0]   = i_B;
  end

  for (genvar k = 0; k < g_stages; k++) begin : g_stage
    stage_tok_t w_tok_src;
    stage_tok_t w_tok_out;
    logic       w_rdy;
    logic       w_rdy_next;

    if (k == 0) begin : g_first
      assign w_tok_src = w_tok_in;
    end else begin : g_chain
      assign w_tok_src = g_stage[k-1].w_tok_out;
    end

    if (k == g_stages - 1) begin : g_last
      assign w_rdy_next = i_ready;
    end else begin : g_mid
      assign w_rdy_next = g_stage[k+1].w_rdy;
    end

    adder_stage #(
      .g_w   (C_W),
      .g_idx (k)
    ) u_stage (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_tok   (w_tok_src),
      .o_ready (w_rdy),
      .i_ready (w_rdy_next),
      .o_tok   (w_tok_out)
    );
  end

  assign w_tok_last = g_stage[g_stages-1].w_tok_out;
  assign o_ready    = g_stage[0].w_rdy;
  assign o_valid    = w_tok_last.valid;
  assign o_C        = {w_tok_last.carry, w_tok_last.sum[g_data_width-1:0]};

  // Consumed operand slices and the mode bit are not needed past the last stage.
  assign w_unused_tok = ^w_tok_last;

endmodule
